// File: rtl/spi_slave.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : spi_slave                                                   |
// | Purpose  : Oversampled SPI responder with single-entry RX/TX buffers.  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module spi_slave #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_in,
  input  logic          rstn_in,
  input  logic          spe_in,
  input  logic          cpol_in,
  input  logic          cpha_in,
  input  logic          lsbfe_in,
  input  logic          spie_in,
  input  logic          sptie_in,
  input  logic          errie_in,
  input  logic [DW-1:0] tx_data_in,
  input  logic          tx_wr_in,
  input  logic          rx_rd_in,
  output logic [DW-1:0] rx_data_out,
  output logic          spif_out,
  output logic          sptef_out,
  output logic          ovrf_out,
  output logic          irq_out,
  input  logic          sck_in,
  input  logic          ss_in,
  input  logic          mosi_in,
  output logic          miso_out,
  output logic          miso_oe_out
);

  localparam int c_CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    IDLE     = 2'd1,
    SHIFT    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_ss_d;

  logic [c_CW-1:0] r_bit_cnt;
  logic [DW-1:0]   r_tx_shift;
  logic [DW-1:0]   r_rx_shift;
  logic [DW-1:0]   r_tx_buf;
  logic [DW-1:0]   r_rx_data;
  logic            r_done;
  logic            r_spif;
  logic            r_sptef;
  logic            r_ovrf;
  logic            r_irq;

  logic w_sck, w_ss, w_mosi;
  logic w_sck_rise, w_sck_fall, w_ss_fall;
  logic w_lead, w_trail;
  logic w_shifting, w_sample, w_drive, w_load;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_ss_fall  = ~w_ss & r_ss_d;
  assign w_lead     = cpol_in ? w_sck_fall : w_sck_rise;
  assign w_trail    = cpol_in ? w_sck_rise : w_sck_fall;

  // The shifting edge is ignored while bit_cnt==0 so the edge that precedes the
  // first sample (CPHA=1) or follows the last one (CPHA=0) never disturbs a fresh load.
  assign w_shifting = spe_in && (r_state == SHIFT) && !w_ss;
  assign w_sample   = w_shifting && (cpha_in ? w_trail : w_lead);
  assign w_drive    = w_shifting && (cpha_in ? w_lead : w_trail) && (r_bit_cnt != '0);
  assign w_load     = spe_in && (((r_state == IDLE) && w_ss_fall) ||
                                 ((r_state == SHIFT) && r_done && !w_ss));

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) r_state <= DISABLED;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DISABLED: if (spe_in)    w_state_next = IDLE;
      IDLE:     if (w_ss_fall) w_state_next = SHIFT;
      SHIFT:    if (w_ss)      w_state_next = IDLE;
      default:                 w_state_next = DISABLED;
    endcase
    if (!spe_in) w_state_next = DISABLED;
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_tx_buf   <= '0;
      r_rx_data  <= '0;
      r_done     <= 1'b0;
      r_spif     <= 1'b0;
      r_sptef    <= 1'b1;
      r_ovrf     <= 1'b0;
    end else if (!spe_in) begin
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_done     <= 1'b0;
      r_spif     <= 1'b0;
      r_sptef    <= 1'b1;
      r_ovrf     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        if (!r_sptef) begin
          r_tx_shift <= r_tx_buf;
          r_sptef    <= 1'b1;
        end else if (tx_wr_in) begin
          r_tx_shift <= tx_data_in;
        end else begin
          r_tx_shift <= '0;
        end
      end else begin
        if (tx_wr_in && r_sptef) begin
          r_tx_buf <= tx_data_in;
          r_sptef  <= 1'b0;
        end
        if (w_drive) begin
          r_tx_shift <= lsbfe_in ? {1'b0, r_tx_shift[DW-1:1]} : {r_tx_shift[DW-2:0], 1'b0};
        end
      end

      if (w_load) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_rx_shift <= lsbfe_in ? {w_mosi, r_rx_shift[DW-1:1]} : {r_rx_shift[DW-2:0], w_mosi};
        if (r_bit_cnt == c_CW'(DW-1)) begin
          r_bit_cnt <= '0;
          r_done    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      // A read landing with completion frees the buffer for the new frame.
      if (r_done) begin
        if (!r_spif || rx_rd_in) begin
          r_rx_data <= r_rx_shift;
          r_spif    <= 1'b1;
          if (rx_rd_in) r_ovrf <= 1'b0;
        end else begin
          r_ovrf <= 1'b1;
        end
      end else if (rx_rd_in) begin
        r_spif <= 1'b0;
        r_ovrf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) r_irq <= 1'b0;
    else          r_irq <= (r_spif & spie_in) | (r_sptef & sptie_in) | (r_ovrf & errie_in);
  end

  assign rx_data_out = r_rx_data;
  assign spif_out    = r_spif;
  assign sptef_out   = r_sptef;
  assign ovrf_out    = r_ovrf;
  assign irq_out     = r_irq;
  assign miso_out    = lsbfe_in ? r_tx_shift[0] : r_tx_shift[DW-1];
  assign miso_oe_out = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// Directed bench for spi_slave: a behavioural SPI master drives frames in each mode.
module tb_spi_slave;
  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic          clk_in = 1'b0;
  logic          rstn_in, spe_in, cpol_in, cpha_in, lsbfe_in;
  logic          spie_in, sptie_in, errie_in;
  logic [DW-1:0] tx_data_in;
  logic          tx_wr_in, rx_rd_in;
  logic [DW-1:0] rx_data_out;
  logic          spif_out, sptef_out, ovrf_out, irq_out;
  logic          sck_in, ss_in, mosi_in, miso_out, miso_oe_out;

  int checks   = 0;
  int failures = 0;
  int lat;
  bit oe_seen;

  spi_slave #(.DW(DW), .SYNC_STAGES(SYNC)) dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .spe_in(spe_in), .cpol_in(cpol_in),
    .cpha_in(cpha_in), .lsbfe_in(lsbfe_in), .spie_in(spie_in), .sptie_in(sptie_in),
    .errie_in(errie_in), .tx_data_in(tx_data_in), .tx_wr_in(tx_wr_in),
    .rx_rd_in(rx_rd_in), .rx_data_out(rx_data_out), .spif_out(spif_out),
    .sptef_out(sptef_out), .ovrf_out(ovrf_out), .irq_out(irq_out),
    .sck_in(sck_in), .ss_in(ss_in), .mosi_in(mosi_in), .miso_out(miso_out),
    .miso_oe_out(miso_oe_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_in);
  endtask

  // Half an SCK period; optionally measures cycles from the last sampling edge to spif.
  task automatic half_wait(input bit track);
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk_in);
      if (miso_oe_out) oe_seen = 1'b1;
      if (track && lat < 0 && spif_out) lat = k + 1;
    end
  endtask

  task automatic wr_pulse(input logic [DW-1:0] d);
    tx_data_in = d; tx_wr_in = 1'b1;
    @(negedge clk_in);
    tx_wr_in = 1'b0;
  endtask

  task automatic rd_pulse();
    rx_rd_in = 1'b1;
    @(negedge clk_in);
    rx_rd_in = 1'b0;
  endtask

  task automatic spi_xfer(input logic [DW-1:0] tx, input int nbits, input bit raise_ss,
                          output logic [DW-1:0] got);
    int idx;
    got = '0; lat = -1; oe_seen = 1'b0;
    ss_in = 1'b0;
    half_wait(1'b0);
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe_in ? i : DW - 1 - i;
      if (!cpha_in) begin
        mosi_in = tx[idx];
        half_wait(1'b0);
        sck_in = ~cpol_in; got[idx] = miso_out;
        half_wait(i == nbits - 1);
        sck_in = cpol_in;
      end else begin
        sck_in = ~cpol_in; mosi_in = tx[idx];
        half_wait(1'b0);
        sck_in = cpol_in; got[idx] = miso_out;
        half_wait(i == nbits - 1);
      end
    end
    if (raise_ss) begin
      half_wait(1'b0);
      ss_in = 1'b1;
      half_wait(1'b0);
    end
  endtask

  task automatic test_reset();
    rstn_in = 1'b0; spe_in = 1'b0; cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0;
    spie_in = 1'b0; sptie_in = 1'b0; errie_in = 1'b0; tx_data_in = '0;
    tx_wr_in = 1'b0; rx_rd_in = 1'b0; sck_in = 1'b0; ss_in = 1'b1; mosi_in = 1'b0;
    wait_cyc(4);
    checks++; if (rx_data_out !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h expected 00", rx_data_out); end
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL reset_spif: got %b expected 0", spif_out); end
    checks++; if (sptef_out !== 1'b1) begin failures++; $display("FAIL reset_sptef: got %b expected 1", sptef_out); end
    checks++; if (ovrf_out !== 1'b0) begin failures++; $display("FAIL reset_ovrf: got %b expected 0", ovrf_out); end
    checks++; if (irq_out !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq_out); end
    checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe_out); end
    rstn_in = 1'b1;
    wait_cyc(2);
    spe_in = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_mode0();
    logic [DW-1:0] got;
    wr_pulse(8'hA5);
    checks++; if (sptef_out !== 1'b0) begin failures++; $display("FAIL mode0_sptef_after_wr: got %b expected 0", sptef_out); end
    spi_xfer(8'h3C, 8, 1'b1, got);
    checks++; if (got !== 8'hA5) begin failures++; $display("FAIL mode0_miso: got %h expected a5", got); end
    checks++; if (rx_data_out !== 8'h3C) begin failures++; $display("FAIL mode0_rx_data: got %h expected 3c", rx_data_out); end
    checks++; if (spif_out !== 1'b1) begin failures++; $display("FAIL mode0_spif: got %b expected 1", spif_out); end
    checks++; if (sptef_out !== 1'b1) begin failures++; $display("FAIL mode0_sptef: got %b expected 1", sptef_out); end
    checks++; if (lat !== SYNC + 2) begin failures++; $display("FAIL mode0_latency: got %0d expected %0d", lat, SYNC + 2); end
    checks++; if (oe_seen !== 1'b1) begin failures++; $display("FAIL mode0_oe_during: got %b expected 1", oe_seen); end
    checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL mode0_oe_after: got %b expected 0", miso_oe_out); end
    spie_in = 1'b1;
    wait_cyc(2);
    checks++; if (irq_out !== 1'b1) begin failures++; $display("FAIL mode0_irq: got %b expected 1", irq_out); end
    spie_in = 1'b0;
    rd_pulse();
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL mode0_rd_spif: got %b expected 0", spif_out); end
    checks++; if (rx_data_out !== 8'h3C) begin failures++; $display("FAIL mode0_rd_hold: got %h expected 3c", rx_data_out); end
  endtask

  task automatic test_modes_lsb();
    logic [DW-1:0] got;
    logic [1:0]    mode;
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      cpol_in = mode[1]; cpha_in = mode[0]; lsbfe_in = 1'b1;
      sck_in = mode[1];
      wait_cyc(6);
      wr_pulse(8'h81);
      spi_xfer(8'h01, 8, 1'b1, got);
      checks++; if (got !== 8'h81) begin failures++; $display("FAIL mode%0d_miso: got %h expected 81", m, got); end
      checks++; if (rx_data_out !== 8'h01) begin failures++; $display("FAIL mode%0d_rx_data: got %h expected 01", m, rx_data_out); end
      checks++; if (spif_out !== 1'b1) begin failures++; $display("FAIL mode%0d_spif: got %b expected 1", m, spif_out); end
      checks++; if (lat !== SYNC + 2) begin failures++; $display("FAIL mode%0d_latency: got %0d expected %0d", m, lat, SYNC + 2); end
      rd_pulse();
    end
    cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0; sck_in = 1'b0;
    wait_cyc(6);
  endtask

  task automatic test_overrun();
    logic [DW-1:0] got;
    errie_in = 1'b1;
    spi_xfer(8'h11, 8, 1'b1, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL underrun_miso: got %h expected 00", got); end
    spi_xfer(8'h22, 8, 1'b1, got);
    checks++; if (rx_data_out !== 8'h11) begin failures++; $display("FAIL ovr_rx_data: got %h expected 11", rx_data_out); end
    checks++; if (ovrf_out !== 1'b1) begin failures++; $display("FAIL ovr_ovrf: got %b expected 1", ovrf_out); end
    checks++; if (irq_out !== 1'b1) begin failures++; $display("FAIL ovr_irq: got %b expected 1", irq_out); end
    rd_pulse();
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL ovr_rd_spif: got %b expected 0", spif_out); end
    checks++; if (ovrf_out !== 1'b0) begin failures++; $display("FAIL ovr_rd_ovrf: got %b expected 0", ovrf_out); end
    @(negedge clk_in);
    checks++; if (irq_out !== 1'b0) begin failures++; $display("FAIL ovr_irq_clear: got %b expected 0", irq_out); end
    errie_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got;
    // Write strobe lands in the load cycle: SYNC cycles of sync plus the edge detect.
    ss_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    wr_pulse(8'h5A);
    spi_xfer(8'hC3, 8, 1'b0, got);
    checks++; if (got !== 8'h5A) begin failures++; $display("FAIL simul_miso: got %h expected 5a", got); end
    checks++; if (sptef_out !== 1'b1) begin failures++; $display("FAIL simul_sptef: got %b expected 1", sptef_out); end
    checks++; if (rx_data_out !== 8'hC3) begin failures++; $display("FAIL simul_rx_data: got %h expected c3", rx_data_out); end
    rd_pulse();
    spi_xfer(8'h3A, 8, 1'b1, got);
    checks++; if (got !== 8'h00) begin failures++; $display("FAIL b2b_miso: got %h expected 00", got); end
    checks++; if (rx_data_out !== 8'h3A) begin failures++; $display("FAIL b2b_rx_data: got %h expected 3a", rx_data_out); end
    checks++; if (ovrf_out !== 1'b0) begin failures++; $display("FAIL b2b_ovrf: got %b expected 0", ovrf_out); end
    rd_pulse();
  endtask

  task automatic test_abort();
    logic [DW-1:0] got;
    spi_xfer(8'hFF, 5, 1'b1, got);
    wait_cyc(4);
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL abort_spif: got %b expected 0", spif_out); end
    checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL abort_oe: got %b expected 0", miso_oe_out); end
    spi_xfer(8'h0F, 8, 1'b1, got);
    checks++; if (rx_data_out !== 8'h0F) begin failures++; $display("FAIL abort_next_rx: got %h expected 0f", rx_data_out); end
    checks++; if (spif_out !== 1'b1) begin failures++; $display("FAIL abort_next_spif: got %b expected 1", spif_out); end
  endtask

  task automatic test_disable();
    logic [DW-1:0] got;
    spi_xfer(8'hAA, 4, 1'b0, got);
    wr_pulse(8'h44);
    checks++; if (sptef_out !== 1'b0) begin failures++; $display("FAIL dis_pre_sptef: got %b expected 0", sptef_out); end
    spe_in = 1'b0;
    wait_cyc(2);
    checks++; if (sptef_out !== 1'b1) begin failures++; $display("FAIL dis_sptef: got %b expected 1", sptef_out); end
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL dis_spif: got %b expected 0", spif_out); end
    checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL dis_oe: got %b expected 0", miso_oe_out); end
    ss_in = 1'b1; sck_in = 1'b0;
    wait_cyc(4);
    spe_in = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] got;
    sptie_in = 1'b1;
    spi_xfer(8'h55, 3, 1'b0, got);
    checks++; if (miso_oe_out !== 1'b1) begin failures++; $display("FAIL rstmid_pre_oe: got %b expected 1", miso_oe_out); end
    checks++; if (irq_out !== 1'b1) begin failures++; $display("FAIL rstmid_pre_irq: got %b expected 1", irq_out); end
    #2 rstn_in = 1'b0;
    #1;
    checks++; if (rx_data_out !== 8'h00) begin failures++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data_out); end
    checks++; if (spif_out !== 1'b0) begin failures++; $display("FAIL rstmid_spif: got %b expected 0", spif_out); end
    checks++; if (sptef_out !== 1'b1) begin failures++; $display("FAIL rstmid_sptef: got %b expected 1", sptef_out); end
    checks++; if (irq_out !== 1'b0) begin failures++; $display("FAIL rstmid_irq: got %b expected 0", irq_out); end
    checks++; if (miso_out !== 1'b0) begin failures++; $display("FAIL rstmid_miso: got %b expected 0", miso_out); end
    checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL rstmid_oe: got %b expected 0", miso_oe_out); end
    @(negedge clk_in);
    ss_in = 1'b1; sck_in = 1'b0; sptie_in = 1'b0;
    wait_cyc(2);
    rstn_in = 1'b1;
    wait_cyc(4);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes_lsb();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (responder) endpoint of the peripheral's SPI interface; pairs with the existing SPI master block on the other end of the bus.
- Oversamples external sck_in, ss_in and mosi_in in the clk_in domain, then shifts one DW-bit frame per transfer in full duplex.
- Exposes single-entry RX and TX buffers with status flags and a combined interrupt to the register block.
- Supports all four CPOL/CPHA modes and MSB-first or LSB-first bit order.

Parameters:
DW, 8, frame width in bits (4..16)
SYNC_STAGES, 2, synchronizer flops on sck_in/ss_in/mosi_in (>=2)

Ports:
clk_in  in  1  system clock
rstn_in  in  1  asynchronous active-low reset
spe_in  in  1  slave enable
cpol_in  in  1  SCK idle level
cpha_in  in  1  0: sample on leading edge; 1: sample on trailing edge
lsbfe_in  in  1  1: LSB first
spie_in  in  1  RX-full interrupt enable
sptie_in  in  1  TX-empty interrupt enable
errie_in  in  1  overrun interrupt enable
tx_data_in  in  DW  TX buffer write data
tx_wr_in  in  1  one-cycle TX buffer write strobe
rx_rd_in  in  1  one-cycle RX buffer read strobe
rx_data_out  out  DW  RX buffer contents
spif_out  out  1  RX buffer full
sptef_out  out  1  TX buffer empty
ovrf_out  out  1  overrun
irq_out  out  1  (spif&spie)|(sptef&sptie)|(ovrf&errie)
sck_in  in  1  SPI clock from master
ss_in  in  1  slave select, active low
mosi_in  in  1  master-out data
miso_out  out  1  slave-out data
miso_oe_out  out  1  MISO output enable

Behaviour:
- Reset is asynchronous on rstn_in low and clock is clk_in. Reset values: rx_data_out=0, spif=0, sptef=1, ovrf=0, irq=0, miso_out=0, miso_oe_out=0, state=DISABLED.
- Synchronization:
  - Each of sck_in, ss_in and mosi_in passes through SYNC_STAGES flops, followed by one edge-detect register on sck.
  - Leading edge is rise when cpol=0 and fall when cpol=1; trailing edge is the opposite edge.
  - sck_in high and low times must each be at least 4 clk_in periods.
- State machine:
  - DISABLED: entered when spe_in=0. Counter and shift registers are cleared, sptef=1, spif=0, ovrf=0. Moves to IDLE when spe_in=1.
  - IDLE: miso_oe=0. On synchronized ss falling, load TX and move to SHIFT.
  - SHIFT: bit_cnt runs 0..DW-1. Synchronized ss rising causes an abort: return to IDLE, partial frame discarded, no flag change.
  - spe_in=0 in any state moves to DISABLED on the next cycle.
- miso_oe_out = (state==SHIFT).
- TX load happens on ss assertion and after every completed frame while ss is still low:
  - If sptef=0: shift_tx<=tx_buf, then sptef<=1.
  - If sptef=1: shift_tx<=0.
  - tx_wr_in in the same cycle as a load with sptef=1: tx_data_in goes straight into shift_tx and sptef stays 1.
- CPHA=0: the first bit is driven on miso at load, sample on leading edge, shift/drive next bit on trailing edge.
- CPHA=1: drive bit on leading edge, sample on trailing edge.
- Bit order: bit index DW-1 down to 0 when lsbfe=0, 0 up to DW-1 when lsbfe=1. Applies to both directions.
- Frame completion:
  - Completes on the DW-th sample. In the next clk_in cycle:
    - If spif=0: rx_data<=shift_rx and spif<=1.
    - Otherwise: ovrf<=1, the frame is dropped, and rx_data is unchanged.
  - Completion in the same cycle as rx_rd_in with spif=1 is treated as spif=0: data loaded, spif stays 1, no overrun.
- rx_rd_in clears spif and ovrf. rx_data_out holds its value.
- tx_wr_in with sptef=1 writes tx_buf and clears sptef. With sptef=0 it is ignored; tx_buf is unchanged.
- Latency: spif rises SYNC_STAGES+2 clk_in cycles after the external sampling edge of the last bit.
- irq_out is registered and updates one cycle after its flags.

Test Plan:
- Mode 0, MSB first: tx_wr 0xA5, master sends 0x3C → miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; spif=1; sptef=1 throughout the frame.
- Modes 1/2/3 plus lsbfe=1: tx 0x81, master sends 0x01 → miso LSB-first pattern 1,0,0,0,0,0,0,1; rx_data=0x01 in all modes.
- Overrun: two frames 0x11 then 0x22 with no rx_rd → rx_data=0x11, ovrf=1, irq=1 (errie=1); rx_rd → spif=0, ovrf=0.
- Underrun/simultaneity: sptef=1 at frame start → miso shifts 0x00. tx_wr coincident with load of 0x5A → 0x5A shifted, sptef stays 1.
- Abort: ss raised after 5 bits of 0xFF → spif stays 0, miso_oe=0. Next full frame 0x0F → rx_data=0x0F.
- Reset/disable mid-frame: rstn_in low at bit 3 → all outputs at reset values immediately. spe_in=0 at bit 4 → DISABLED, sptef=1, spif=0.
